serial_sub_ctrl: RTL and testbench

- Bit-serial N-bit subtract controller built around the team's one-bit full-subtractor cell (x - y - z -> D, B).
- Captures operands on a start handshake, then feeds the cell one bit pair per clock, LSB first, through a registered borrow chain.
- Reports the difference, final borrow and signed overflow with a one-cycle done pulse.
- Sits between a register-file/host sequencer and the shared subtractor cell, replacing a WIDTH-wide ripple array.

---
 rtl/serial_sub_ctrl.sv | 114 +++++++++++
 tb/tb_serial_sub_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtract controller: feeds a one-bit full-subtractor cell LSB first
// through a registered borrow chain and reports diff, borrow out and signed overflow.
module serial_sub_ctrl #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_borrow_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow_out,
  output logic             o_ovf
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-2:0]   r_res_sh;
  logic               r_borrow;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_a_msb;
  logic               r_b_msb;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow_out;
  logic               r_ovf;

  logic               w_x;
  logic               w_y;
  logic               w_z;
  logic               w_cell_d;
  logic               w_cell_b;
  logic               w_last;
  logic [WIDTH-1:0]   w_res_next;

  // One-bit full-subtractor cell: x - y - z -> D, B
  assign w_x      = r_a_sh[0];
  assign w_y      = r_b_sh[0];
  assign w_z      = r_borrow;
  assign w_cell_d = w_x ^ w_y ^ w_z;
  assign w_cell_b = (~w_x & (w_y | w_z)) | (w_y & w_z);

  // Result bits enter at the MSB end so the LSB-first stream lands in place
  assign w_res_next = {w_cell_d, r_res_sh};
  assign w_last     = (r_cnt == LastCnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_next = StRun;
      StRun:   if (w_last)  w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_res_sh     <= '0;
      r_borrow     <= 1'b0;
      r_cnt        <= '0;
      r_a_msb      <= 1'b0;
      r_b_msb      <= 1'b0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
      r_ovf        <= 1'b0;
    end else if (r_state == StIdle && i_start) begin
      r_a_sh   <= i_a;
      r_b_sh   <= i_b;
      r_borrow <= i_borrow_in;
      r_cnt    <= '0;
      r_a_msb  <= i_a[WIDTH-1];
      r_b_msb  <= i_b[WIDTH-1];
    end else if (r_state == StRun) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_res_sh <= w_res_next[WIDTH-1:1];
      r_borrow <= w_cell_b;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_diff       <= w_res_next;
        r_borrow_out <= w_cell_b;
        // Overflow only possible when operand signs differ
        r_ovf        <= (r_a_msb != r_b_msb) && (w_cell_d != r_a_msb);
      end
    end
  end

  assign o_busy       = (r_state == StRun);
  assign o_done       = (r_state == StDone);
  assign o_diff       = r_diff;
  assign o_borrow_out = r_borrow_out;
  assign o_ovf        = r_ovf;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: directed cases, random operands, an exhaustive
// WIDTH=2 sweep, start/operand interference, back-to-back starts and mid-run reset.
module tb_serial_sub_ctrl;

  logic       clk;
  logic       rst_n;
  logic       i_start;
  logic [7:0] i_a;
  logic [7:0] i_b;
  logic       i_borrow_in;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_diff;
  logic       o_borrow_out;
  logic       o_ovf;

  logic       s2_start;
  logic [1:0] s2_a;
  logic [1:0] s2_b;
  logic       s2_borrow_in;
  logic       s2_busy;
  logic       s2_done;
  logic [1:0] s2_diff;
  logic       s2_borrow_out;
  logic       s2_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  serial_sub_ctrl #(.WIDTH(8)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_a          (i_a),
    .i_b          (i_b),
    .i_borrow_in  (i_borrow_in),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_diff       (o_diff),
    .o_borrow_out (o_borrow_out),
    .o_ovf        (o_ovf)
  );

  serial_sub_ctrl #(.WIDTH(2)) u_dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (s2_start),
    .i_a          (s2_a),
    .i_b          (s2_b),
    .i_borrow_in  (s2_borrow_in),
    .o_busy       (s2_busy),
    .o_done       (s2_done),
    .o_diff       (s2_diff),
    .o_borrow_out (s2_borrow_out),
    .o_ovf        (s2_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Plain-arithmetic reference: unsigned difference, borrow, signed range overflow
  function automatic void model(input int w, input int a, input int b, input int bin,
                                output int d, output int bo, output int ov);
    int m;
    int sa;
    int sb;
    int r;
    int s;
    m  = 1 << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    r  = a - b - bin;
    d  = ((r % m) + m) % m;
    bo = (r < 0) ? 1 : 0;
    s  = sa - sb - bin;
    ov = (s < -(m / 2) || s >= m / 2) ? 1 : 0;
  endfunction

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input string tag);
    int         ed;
    int         eb;
    int         eo;
    int         ncyc;
    int         nbusy;
    logic       held;
    logic [7:0] prev;
    model(8, int'(a), int'(b), int'(bin), ed, eb, eo);
    @(posedge clk);
    #1;
    prev        = o_diff;
    i_a         = a;
    i_b         = b;
    i_borrow_in = bin;
    i_start     = 1'b1;
    @(posedge clk);
    #1;
    i_start     = 1'b0;
    i_a         = 8'($urandom);
    i_b         = 8'($urandom);
    i_borrow_in = 1'($urandom);
    ncyc  = 0;
    nbusy = 0;
    held  = 1'b1;
    @(negedge clk);
    while (!o_done && ncyc < 50) begin
      if (o_busy) nbusy++;
      if (o_diff !== prev) held = 1'b0;
      ncyc++;
      @(negedge clk);
    end
    check({tag, " latency"}, ncyc, 8);
    check({tag, " busy_cycles"}, nbusy, 8);
    check({tag, " diff_held"}, held, 1);
    check({tag, " diff"}, o_diff, ed);
    check({tag, " borrow_out"}, o_borrow_out, eb);
    check({tag, " ovf"}, o_ovf, eo);
    @(negedge clk);
    check({tag, " done_single"}, o_done, 0);
  endtask

  task automatic do_op2(input logic [1:0] a, input logic [1:0] b, input logic bin);
    int ed;
    int eb;
    int eo;
    int ncyc;
    model(2, int'(a), int'(b), int'(bin), ed, eb, eo);
    @(posedge clk);
    #1;
    s2_a         = a;
    s2_b         = b;
    s2_borrow_in = bin;
    s2_start     = 1'b1;
    @(posedge clk);
    #1;
    s2_start = 1'b0;
    ncyc     = 0;
    @(negedge clk);
    while (!s2_done && ncyc < 20) begin
      ncyc++;
      @(negedge clk);
    end
    check($sformatf("w2 %0d-%0d-%0d lat", a, b, bin), ncyc, 2);
    check($sformatf("w2 %0d-%0d-%0d diff", a, b, bin), s2_diff, ed);
    check($sformatf("w2 %0d-%0d-%0d bo", a, b, bin), s2_borrow_out, eb);
    check($sformatf("w2 %0d-%0d-%0d ovf", a, b, bin), s2_ovf, eo);
  endtask

  initial begin
    int ndone;
    int t[3];
    int cyc;
    int nd;

    rst_n        = 1'b0;
    i_start      = 1'b0;
    i_a          = '0;
    i_b          = '0;
    i_borrow_in  = 1'b0;
    s2_start     = 1'b0;
    s2_a         = '0;
    s2_b         = '0;
    s2_borrow_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst busy", o_busy, 0);
    check("rst done", o_done, 0);
    check("rst diff", o_diff, 0);
    check("rst borrow_out", o_borrow_out, 0);
    check("rst ovf", o_ovf, 0);
    rst_n = 1'b1;

    do_op(8'h35, 8'h12, 1'b0, "35-12");
    do_op(8'h12, 8'h35, 1'b0, "12-35");
    do_op(8'h80, 8'h01, 1'b0, "80-01");
    do_op(8'h00, 8'h00, 1'b1, "00-00-1");
    do_op(8'h5A, 8'h5A, 1'b1, "eq_bin");
    do_op(8'h80, 8'h00, 1'b1, "80-00-1");
    do_op(8'h7F, 8'hFF, 1'b0, "7F-FF");

    for (int i = 0; i < 30; i++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
    end

    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < 2; c++) begin
          do_op2(2'(a), 2'(b), 1'(c));
        end
      end
    end

    // Start pulses during RUN and DONE plus operand churn must be ignored
    @(posedge clk);
    #1;
    i_a = 8'h35; i_b = 8'h12; i_borrow_in = 1'b0; i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    nd = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      i_start     = (k == 2 || k == 8);
      i_a         = 8'($urandom);
      i_b         = 8'($urandom);
      i_borrow_in = 1'($urandom);
      @(negedge clk);
      if (o_done) nd++;
      if (k == 8) check("ignore diff", o_diff, 8'h23);
      if (k == 9) check("ignore busy_k9", o_busy, 0);
      if (k == 10) check("ignore busy_k10", o_busy, 0);
    end
    i_start = 1'b0;
    check("ignore done_count", nd, 1);

    // Start held high: back-to-back operations
    @(posedge clk);
    #1;
    i_a = 8'h35; i_b = 8'h12; i_borrow_in = 1'b0; i_start = 1'b1;
    ndone = 0;
    cyc   = 0;
    while (ndone < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (o_done) begin
        t[ndone] = cyc;
        ndone++;
        check("held diff", o_diff, 8'h23);
      end
    end
    i_start = 1'b0;
    check("held count", ndone, 3);
    check("held spacing1", t[1] - t[0], 10);
    check("held spacing2", t[2] - t[1], 10);
    repeat (4) @(negedge clk);

    // Mid-run asynchronous reset
    @(posedge clk);
    #1;
    i_a = 8'h35; i_b = 8'h12; i_borrow_in = 1'b0; i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst busy", o_busy, 0);
    check("arst done", o_done, 0);
    check("arst diff", o_diff, 0);
    check("arst borrow_out", o_borrow_out, 0);
    check("arst ovf", o_ovf, 0);
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (o_done) nd++;
      if (k == 2) rst_n = 1'b1;
    end
    check("arst no_done", nd, 0);
    do_op(8'h35, 8'h12, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
